frog_sprite_renderer: RTL and testbench

FROG_SPRITE_RENDERER -- requirements
Module: frog_sprite_renderer

---
 rtl/frog_sprite_renderer_pkg.sv | 45 ++++
 rtl/frog_sprite_renderer_rom.sv | 29 ++
 rtl/frog_sprite_renderer.sv | 128 ++++++++++++
 tb/tb_frog_sprite_renderer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_sprite_renderer_pkg.sv
// Shared game constants: playfield geometry, colour format, palette and the frog sprite image.
// The movement block imports the same package so both agree on tile size and screen bounds.
package frog_sprite_renderer_pkg;

  localparam int GAME_TILE_SIZE = 32;
  localparam int GAME_H_VISIBLE = 640;
  localparam int GAME_V_VISIBLE = 480;
  localparam int COORD_W        = 10;
  localparam int RGB_W          = 9;
  localparam int PAL_IDX_W      = 3;
  localparam int ROM_ADDR_W     = 8;

  // 3:3:3 RGB, index 0 is never displayed (transparent)
  localparam logic [RGB_W-1:0] PALETTE [8] = '{
    9'h000, 9'h038, 9'h018, 9'h1F8, 9'h1FF, 9'h049, 9'h1C0, 9'h03F
  };

  // 16x16 frog, one hex digit per texel, leftmost digit is texel column 0
  localparam logic [63:0] FROG_IMAGE [16] = '{
    64'h0004_4000_0004_4000,
    64'h0045_5400_0045_5400,
    64'h0044_4400_0044_4400,
    64'h0011_1111_1111_1100,
    64'h0111_1111_1111_1110,
    64'h1112_2222_2222_2111,
    64'h1122_2223_3222_2211,
    64'h0122_2333_3332_2210,
    64'h0122_2333_3332_2210,
    64'h0112_2222_2222_2110,
    64'h0011_1226_6221_1100,
    64'h0001_1111_1111_1000,
    64'h0011_1000_0001_1100,
    64'h0110_0000_0000_0110,
    64'h1100_0000_0000_0011,
    64'h7700_0000_0000_0077
  };

  // Address is {texel_row, texel_col}; texel column 0 sits in the top nibble of the row word.
  function automatic logic [PAL_IDX_W-1:0] sprite_index(input logic [ROM_ADDR_W-1:0] addr);
    logic [5:0] lsb;
    lsb = {~addr[3:0], 2'b00};
    return FROG_IMAGE[addr[7:4]][lsb +: PAL_IDX_W];
  endfunction

endpackage

// File: rtl/frog_sprite_renderer_rom.sv
// 256x3 frog sprite ROM with a registered (synchronous) read port.
// Contents are folded from the package image so synthesis builds a block ROM without an init file.
module frog_sprite_rom
  import frog_sprite_renderer_pkg::*;
(
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [ROM_ADDR_W-1:0] i_Addr,
  output logic [PAL_IDX_W-1:0]  o_Index
);

  logic [PAL_IDX_W-1:0] index_d;
  logic [PAL_IDX_W-1:0] index_q;

  always_comb begin
    index_d = sprite_index(i_Addr);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign o_Index = index_q;

endmodule

// File: rtl/frog_sprite_renderer.sv
// Three-stage frog sprite overlay: hit test / ROM address, ROM read, palette lookup.
// Frog position is shadowed once per frame at the start of vertical blanking so a frame never tears.
module frog_sprite_renderer
  import frog_sprite_renderer_pkg::*;
#(
  parameter int               TILE_SIZE      = GAME_TILE_SIZE,
  parameter int               H_VISIBLE_AREA = GAME_H_VISIBLE,
  parameter int               V_VISIBLE_AREA = GAME_V_VISIBLE,
  parameter logic [RGB_W-1:0] BG_COLOR       = 9'h000
)(
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_HSync,
  input  logic               i_VSync,
  input  logic [COORD_W-1:0] i_Col_Count,
  input  logic [COORD_W-1:0] i_Row_Count,
  input  logic [COORD_W-1:0] i_Frog_X,
  input  logic [COORD_W-1:0] i_Frog_Y,
  input  logic               i_Draw_Frog,
  output logic [2:0]         o_Red,
  output logic [2:0]         o_Grn,
  output logic [2:0]         o_Blu,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_Frog_Pixel
);

  // Screen pixels per texel is 2^ADDR_SHIFT (sprite is 16x16 texels)
  localparam int ADDR_SHIFT = $clog2(TILE_SIZE) - 4;

  logic [COORD_W-1:0]    shadow_x_d, shadow_x_q;
  logic [COORD_W-1:0]    shadow_y_d, shadow_y_q;
  logic                  shadow_draw_d, shadow_draw_q;
  logic [ROM_ADDR_W-1:0] s1_addr_d, s1_addr_q;
  logic                  s1_hit_d, s1_hit_q;
  logic                  s1_vis_d, s1_vis_q;
  logic                  s2_hit_d, s2_hit_q;
  logic                  s2_vis_d, s2_vis_q;
  logic [PAL_IDX_W-1:0]  s2_index;
  logic [RGB_W-1:0]      rgb_d, rgb_q;
  logic                  frog_pix_d, frog_pix_q;
  logic [2:0]            hsync_pipe_d, hsync_pipe_q;
  logic [2:0]            vsync_pipe_d, vsync_pipe_q;

  logic                  latch;
  logic [COORD_W:0]      col_w, row_w, x_w, y_w;

  always_comb begin
    latch         = (i_Row_Count == COORD_W'(V_VISIBLE_AREA)) && (i_Col_Count == '0);
    shadow_x_d    = latch ? i_Frog_X    : shadow_x_q;
    shadow_y_d    = latch ? i_Frog_Y    : shadow_y_q;
    shadow_draw_d = latch ? i_Draw_Frog : shadow_draw_q;

    // 11-bit compares so X+TILE_SIZE at the right edge cannot wrap back to column 0
    col_w = {1'b0, i_Col_Count};
    row_w = {1'b0, i_Row_Count};
    x_w   = {1'b0, shadow_x_q};
    y_w   = {1'b0, shadow_y_q};

    s1_vis_d  = (col_w < (COORD_W+1)'(H_VISIBLE_AREA)) && (row_w < (COORD_W+1)'(V_VISIBLE_AREA));
    s1_hit_d  = shadow_draw_q && s1_vis_d &&
                (col_w >= x_w) && (col_w < x_w + (COORD_W+1)'(TILE_SIZE)) &&
                (row_w >= y_w) && (row_w < y_w + (COORD_W+1)'(TILE_SIZE));
    s1_addr_d = {4'((row_w - y_w) >> ADDR_SHIFT), 4'((col_w - x_w) >> ADDR_SHIFT)};

    s2_hit_d = s1_hit_q;
    s2_vis_d = s1_vis_q;

    rgb_d      = '0;
    frog_pix_d = 1'b0;
    if (s2_vis_q) begin
      if (s2_hit_q && (s2_index != '0)) begin
        rgb_d      = PALETTE[s2_index];
        frog_pix_d = 1'b1;
      end else begin
        rgb_d = BG_COLOR;
      end
    end

    hsync_pipe_d = {hsync_pipe_q[1:0], i_HSync};
    vsync_pipe_d = {vsync_pipe_q[1:0], i_VSync};
  end

  frog_sprite_rom u_rom (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Addr  (s1_addr_q),
    .o_Index (s2_index)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      shadow_x_q    <= '0;
      shadow_y_q    <= '0;
      shadow_draw_q <= 1'b0;
      s1_addr_q     <= '0;
      s1_hit_q      <= 1'b0;
      s1_vis_q      <= 1'b0;
      s2_hit_q      <= 1'b0;
      s2_vis_q      <= 1'b0;
      rgb_q         <= '0;
      frog_pix_q    <= 1'b0;
      hsync_pipe_q  <= '0;
      vsync_pipe_q  <= '0;
    end else begin
      shadow_x_q    <= shadow_x_d;
      shadow_y_q    <= shadow_y_d;
      shadow_draw_q <= shadow_draw_d;
      s1_addr_q     <= s1_addr_d;
      s1_hit_q      <= s1_hit_d;
      s1_vis_q      <= s1_vis_d;
      s2_hit_q      <= s2_hit_d;
      s2_vis_q      <= s2_vis_d;
      rgb_q         <= rgb_d;
      frog_pix_q    <= frog_pix_d;
      hsync_pipe_q  <= hsync_pipe_d;
      vsync_pipe_q  <= vsync_pipe_d;
    end
  end

  assign o_Red        = rgb_q[8:6];
  assign o_Grn        = rgb_q[5:3];
  assign o_Blu        = rgb_q[2:0];
  assign o_Frog_Pixel = frog_pix_q;
  assign o_HSync      = hsync_pipe_q[2];
  assign o_VSync      = vsync_pipe_q[2];

endmodule

// File: tb/tb_frog_sprite_renderer.sv
// Bench for frog_sprite_renderer: drives scan positions directly and compares every output
// pixel, three cycles later, against a plain-arithmetic model of the frame.
module tb_frog_sprite_renderer;

  localparam int TILE = 32;
  localparam int HVIS = 640;
  localparam int VVIS = 480;
  localparam logic [8:0] BG = 9'h000;

  localparam logic [8:0] pal [8] = '{
    9'h000, 9'h038, 9'h018, 9'h1F8, 9'h1FF, 9'h049, 9'h1C0, 9'h03F
  };
  localparam logic [63:0] img [16] = '{
    64'h0004_4000_0004_4000, 64'h0045_5400_0045_5400,
    64'h0044_4400_0044_4400, 64'h0011_1111_1111_1100,
    64'h0111_1111_1111_1110, 64'h1112_2222_2222_2111,
    64'h1122_2223_3222_2211, 64'h0122_2333_3332_2210,
    64'h0122_2333_3332_2210, 64'h0112_2222_2222_2110,
    64'h0011_1226_6221_1100, 64'h0001_1111_1111_1000,
    64'h0011_1000_0001_1100, 64'h0110_0000_0000_0110,
    64'h1100_0000_0000_0011, 64'h7700_0000_0000_0077
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_HSync = 1'b0, i_VSync = 1'b0;
  logic [9:0] i_Col_Count = 10'd700, i_Row_Count = 10'd500;
  logic [9:0] i_Frog_X = '0, i_Frog_Y = '0;
  logic       i_Draw_Frog = 1'b0;
  logic [2:0] o_Red, o_Grn, o_Blu;
  logic       o_HSync, o_VSync, o_Frog_Pixel;

  frog_sprite_renderer dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_HSync      (i_HSync),
    .i_VSync      (i_VSync),
    .i_Col_Count  (i_Col_Count),
    .i_Row_Count  (i_Row_Count),
    .i_Frog_X     (i_Frog_X),
    .i_Frog_Y     (i_Frog_Y),
    .i_Draw_Frog  (i_Draw_Frog),
    .o_Red        (o_Red),
    .o_Grn        (o_Grn),
    .o_Blu        (o_Blu),
    .o_HSync      (o_HSync),
    .o_VSync      (o_VSync),
    .o_Frog_Pixel (o_Frog_Pixel)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // values the bench will present on the frog inputs at the next step
  int nx = 0, ny = 0;
  bit ndraw = 0;
  // model of the per-frame shadow
  int m_x = 0, m_y = 0;
  bit m_draw = 0;

  // scoreboard: {hsync, vsync, frog_pixel, rgb}
  logic [11:0] exp_q[$];
  int          pos_q[$];

  function automatic int texel(int r, int c);
    return int'((img[r] >> (4 * (15 - c))) & 64'h7);
  endfunction

  function automatic logic [11:0] model_pixel(int col, int row, bit hs, bit vs);
    logic [8:0] rgb;
    bit fp;
    int t;
    rgb = 9'h000;
    fp  = 0;
    if (col < HVIS && row < VVIS) begin
      rgb = BG;
      if (m_draw && col >= m_x && col < m_x + TILE && row >= m_y && row < m_y + TILE) begin
        t = texel((row - m_y) / 2, (col - m_x) / 2);
        if (t != 0) begin
          rgb = pal[t];
          fp  = 1;
        end
      end
    end
    return {hs, vs, fp, rgb};
  endfunction

  // driver: one scan position per clock; compares the pixel driven three steps ago
  task automatic step(int col, int row, bit hs, bit vs);
    logic [11:0] exp, act;
    int p;
    @(negedge clk);
    if (exp_q.size() == 3) begin
      exp = exp_q.pop_front();
      p   = pos_q.pop_front();
      act = {o_HSync, o_VSync, o_Frog_Pixel, o_Red, o_Grn, o_Blu};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL pixel col=%0d row=%0d: got %03h expected %03h", p / 4096, p % 4096, act, exp);
      end
    end
    i_Col_Count = 10'(col);
    i_Row_Count = 10'(row);
    i_HSync     = hs;
    i_VSync     = vs;
    i_Frog_X    = 10'(nx);
    i_Frog_Y    = 10'(ny);
    i_Draw_Frog = ndraw;
    exp_q.push_back(model_pixel(col, row, hs, vs));
    pos_q.push_back(col * 4096 + row);
    if (row == VVIS && col == 0) begin
      m_x    = nx;
      m_y    = ny;
      m_draw = ndraw;
    end
  endtask

  task automatic latch_frame();
    step(0, VVIS, 0, 1);
  endtask

  task automatic flush();
    repeat (3) step(700, 500, 0, 0);
  endtask

  task automatic check_outputs_zero(string name);
    logic [11:0] act;
    act = {o_HSync, o_VSync, o_Frog_Pixel, o_Red, o_Grn, o_Blu};
    checks++;
    if (act !== 12'h000) begin
      errors++;
      $display("FAIL %s: outputs %03h expected 000", name, act);
    end
  endtask

  task automatic do_reset(int hold);
    @(negedge clk);
    rst         = 1'b1;
    i_Col_Count = 10'd700;
    i_Row_Count = 10'd500;
    i_HSync     = 1'b0;
    i_VSync     = 1'b0;
    #1;
    check_outputs_zero("reset_immediate");
    m_x    = 0;
    m_y    = 0;
    m_draw = 0;
    repeat (hold) @(negedge clk);
    check_outputs_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    pos_q.delete();
    repeat (3) begin
      exp_q.push_back(12'h000);
      pos_q.push_back(700 * 4096 + 500);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    nx = 0; ny = 0; ndraw = 1;
    for (int c = 0; c < 20; c++) step(c, 0, 0, 0);
    flush();
  endtask

  task automatic test_origin();
    int rows[5] = '{0, 1, 9, 31, 32};
    nx = 0; ny = 0; ndraw = 1;
    latch_frame();
    foreach (rows[i]) begin
      for (int c = 0; c <= 40; c++) step(c, rows[i], c >= 36, 0);
    end
    flush();
  endtask

  task automatic test_midframe_move();
    nx = 64; ny = 90; ndraw = 1;
    latch_frame();
    for (int c = 56; c <= 100; c++) step(c, 100, 0, 0);
    nx = 96;
    for (int c = 56; c <= 135; c++) step(c, 101, 0, 0);
    latch_frame();
    for (int c = 56; c <= 135; c++) step(c, 101, 0, 0);
    step(639, 479, 0, 0);
    nx = 128;
    latch_frame();
    nx = 300;
    for (int c = 120; c <= 165; c++) step(c, 100, 0, 0);
    flush();
  endtask

  task automatic test_no_draw();
    nx = 200; ny = 200; ndraw = 0;
    latch_frame();
    ndraw = 1;
    repeat (150) step($urandom_range(190, 240), $urandom_range(190, 240),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    flush();
  endtask

  task automatic test_corner();
    int rows[6] = '{447, 448, 463, 479, 480, 481};
    nx = HVIS - TILE; ny = VVIS - TILE; ndraw = 1;
    latch_frame();
    foreach (rows[i]) begin
      for (int c = 600; c <= 660; c++) step(c, rows[i], 0, 0);
    end
    for (int c = 0; c < 6; c++) step(c, 460, 0, 0);
    step(1023, 460, 0, 0);
    step(620, 1023, 0, 0);
    flush();
  endtask

  task automatic test_sync();
    int gap, w;
    for (int p = 0; p < 4; p++) begin
      gap = $urandom_range(2, 6);
      w   = $urandom_range(1, 8);
      repeat (gap) step($urandom_range(0, 700), $urandom_range(0, 500), 0, 0);
      for (int k = 0; k < w; k++) step($urandom_range(0, 700), $urandom_range(0, 500), 1, p[0]);
    end
    flush();
  endtask

  task automatic test_random();
    int col, row;
    for (int f = 0; f < 4; f++) begin
      nx = $urandom_range(0, 620); ny = $urandom_range(0, 460); ndraw = ($urandom_range(0, 3) != 0);
      latch_frame();
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          col = $urandom_range(0, 1023);
          row = $urandom_range(0, 1023);
        end else begin
          col = (m_x >= 4 ? m_x - 4 : 0) + $urandom_range(0, 40);
          row = (m_y >= 4 ? m_y - 4 : 0) + $urandom_range(0, 40);
        end
        if (k == 75) nx = $urandom_range(0, 620);
        step(col, row, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    flush();
  endtask

  task automatic test_reset_mid();
    nx = 0; ny = 0; ndraw = 1;
    latch_frame();
    for (int c = 0; c <= 10; c++) step(c, 2, 1, 0);
    do_reset(2);
    for (int c = 0; c <= 20; c++) step(c, 2, 0, 0);
    latch_frame();
    for (int c = 0; c <= 20; c++) step(c, 2, 0, 0);
    flush();
  endtask

  initial begin
    test_reset();
    test_origin();
    test_midframe_move();
    test_no_draw();
    test_corner();
    test_sync();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
